// File: rtl/mult_iter.sv
`timescale 1ns/1ps
// Iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits retired per CALC cycle.
// Result after WIDTH/BITS_PER_CYCLE+1 cycles; dropping mult_begin mid-CALC aborts the operation.
module mult_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mult_begin,
  input  logic                 mult_signed,
  input  logic [WIDTH-1:0]     mult_op1,
  input  logic [WIDTH-1:0]     mult_op2,
  output logic [2*WIDTH-1:0]   product,
  output logic                 mult_end,
  output logic                 mult_busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int PW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   product_q, product_d;

  logic [WIDTH-1:0] mag1, mag2;
  logic [PW-1:0]    partial, acc_sum;

  // Signed operands are reduced to magnitudes; the sign is reapplied once at the end.
  assign mag1 = (mult_signed && mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
  assign mag2 = (mult_signed && mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;

  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
    acc_sum = acc_q + partial;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (mult_begin) begin
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          neg_d    = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (!mult_begin) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          count_d  = count_q + CW'(1);
          if (count_q == LAST) begin
            product_d = neg_q ? -acc_sum : acc_sum;
            state_d   = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product   = product_q;
  assign mult_end  = (state_q == DONE);
  assign mult_busy = (state_q != IDLE);

endmodule

// File: tb/tb_mult_iter.sv
`timescale 1ns/1ps
// Bench for mult_iter: default (1 bit/cycle) and 4 bits/cycle instances against a 64-bit arithmetic model.
module tb_mult_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        b0, s0, e0, y0;
  logic [31:0] a0, c0;
  logic [63:0] p0;
  logic        b4, s4, e4, y4;
  logic [31:0] a4, c4;
  logic [63:0] p4;

  int total = 0;
  int bad   = 0;

  mult_iter dut (
    .clk(clk), .resetn(resetn), .mult_begin(b0), .mult_signed(s0),
    .mult_op1(a0), .mult_op2(c0), .product(p0), .mult_end(e0), .mult_busy(y0)
  );

  mult_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .resetn(resetn), .mult_begin(b4), .mult_signed(s4),
    .mult_op1(a4), .mult_op2(c4), .product(p4), .mult_end(e4), .mult_busy(y4)
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic bg, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (w == 0) begin b0 = bg; a0 = a; c0 = b; s0 = s; end
    else        begin b4 = bg; a4 = a; c4 = b; s4 = s; end
  endtask

  function automatic logic end_of(input int w);
    return (w == 0) ? e0 : e4;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? y0 : y4;
  endfunction
  function automatic logic [63:0] prod_of(input int w);
    return (w == 0) ? p0 : p4;
  endfunction

  // One complete operation: begin held from cycle 0 until mult_end is seen.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int lat, input string tag);
    logic [63:0] exp;
    int got, n;
    exp = model(a, b, s);
    got = -1;
    n   = 0;
    drive(w, 1'b1, a, b, s);
    for (int c = 1; c <= lat + 4; c++) begin
      tick();
      if (c == 1) chk({tag, "_busy"}, 64'(busy_of(w)), 64'd1);
      if (end_of(w)) begin
        n++;
        if (got < 0) begin
          got = c;
          chk({tag, "_prod"}, prod_of(w), exp);
          drive(w, 1'b0, a, b, s);
        end
      end
    end
    if (got < 0) drive(w, 1'b0, a, b, s);
    chk({tag, "_endcyc"}, 64'(got), 64'(lat));
    chk({tag, "_endcnt"}, 64'(n), 64'd1);
    chk({tag, "_idle"}, 64'(busy_of(w)), 64'd0);
    chk({tag, "_hold"}, prod_of(w), exp);
  endtask

  initial begin
    logic [63:0] last;
    int n, first, second;
    logic [31:0] ra, rb;
    logic rs;

    resetn = 1'b0;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
    #2;
    chk("rst_prod", p0, 64'd0);
    chk("rst_end", 64'(e0), 64'd0);
    chk("rst_busy", 64'(y0), 64'd0);
    chk("rst_prod4", p4, 64'd0);
    #10 resetn = 1'b1;
    tick();

    run_op(0, 32'd7, 32'hFFFFFFFD, 1'b1, 33, "s_7x-3");
    run_op(0, 32'h80000000, 32'h80000000, 1'b1, 33, "s_min2");
    run_op(0, 32'h80000000, 32'd1, 1'b1, 33, "s_minx1");
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, "u_max2");
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33, "s_m1m1");
    run_op(0, 32'd0, 32'hDEADBEEF, 1'b0, 33, "u_zero");
    last = model(32'd0, 32'hDEADBEEF, 1'b0);
    run_op(0, 32'd12345, 32'd2, 1'b0, 33, "u_small");
    last = model(32'd12345, 32'd2, 1'b0);

    // Abort: drop begin in cycle 10.
    n = 0;
    drive(0, 1'b1, 32'h1234, 32'h5678, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (e0) n++;
      if (c == 10) drive(0, 1'b0, 32'h1234, 32'h5678, 1'b0);
      if (c == 11) chk("abort_idle", 64'(y0), 64'd0);
    end
    chk("abort_noend", 64'(n), 64'd0);
    chk("abort_prod", p0, last);

    // Asynchronous reset in cycle 20 of an operation.
    n = 0;
    drive(0, 1'b1, 32'h7, 32'h9, 1'b0);
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (e0) n++;
      if (c == 20) begin
        resetn = 1'b0;
        drive(0, 1'b0, 32'h7, 32'h9, 1'b0);
        #2;
        chk("rstmid_prod", p0, 64'd0);
        chk("rstmid_busy", 64'(y0), 64'd0);
        resetn = 1'b1;
      end
    end
    chk("rstmid_noend", 64'(n), 64'd0);
    chk("rstmid_hold", p0, 64'd0);

    // Back-to-back: begin held across 3*5 then 0*123.
    n = 0; first = -1; second = -1;
    drive(0, 1'b1, 32'd3, 32'd5, 1'b0);
    for (int c = 1; c <= 72; c++) begin
      tick();
      if (e0) begin
        n++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (c == 33) begin
        chk("b2b_p33", p0, model(32'd3, 32'd5, 1'b0));
        drive(0, 1'b1, 32'd0, 32'd123, 1'b0);
      end
      if (c == 50) chk("b2b_p50", p0, model(32'd3, 32'd5, 1'b0));
      if (c == 66) chk("b2b_p66", p0, model(32'd3, 32'd5, 1'b0));
      if (c == 67) begin
        chk("b2b_p67", p0, model(32'd0, 32'd123, 1'b0));
        drive(0, 1'b0, 32'd0, 32'd123, 1'b0);
      end
    end
    chk("b2b_first", 64'(first), 64'd33);
    chk("b2b_second", 64'(second), 64'd67);
    chk("b2b_cnt", 64'(n), 64'd2);

    // Four bits per cycle.
    run_op(1, 32'd12345, -32'd678, 1'b1, 9, "q_12345x-678");
    run_op(1, 32'h80000000, 32'h80000000, 1'b1, 9, "q_min2");
    run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 9, "q_umax");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_op(0, ra, rb, rs, 33, "rnd1");
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      run_op(1, ra, rb, rs, 9, "rnd4");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
